// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: operation codes and their width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package register_bank_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP = 3'd0;
  localparam op_t OP_LD  = 3'd1;
  localparam op_t OP_INC = 3'd2;
  localparam op_t OP_DEC = 3'd3;
  localparam op_t OP_SHL = 3'd4;
  localparam op_t OP_SHR = 3'd5;
  localparam op_t OP_CLR = 3'd6;
  // Code 7 is reserved and decodes as an invalid (no-op) operation.

endpackage

// File: rtl/register_bank_op_unit.sv
// Purpose: combinational evaluation of one register-local operation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; a result is produced for every input.
// Ports: cur_val (current register), op, wr_data (LOAD value) ->
//        result, carry_out, valid_op (1 for codes that modify state).
module reg_op_unit
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_val,
  input  op_t              op,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             valid_op
);

  always_comb begin
    result    = cur_val;
    carry_out = 1'b0;
    valid_op  = 1'b1;
    case (op)
      OP_LD:  result = wr_data;
      // Extend by one bit so the wrap-around carry falls out of the add.
      OP_INC: {carry_out, result} = {1'b0, cur_val} + (WIDTH+1)'(1);
      OP_DEC: begin
        result    = cur_val - WIDTH'(1);
        carry_out = (cur_val == '0);
      end
      OP_SHL: {carry_out, result} = {cur_val, 1'b0};
      OP_SHR: {result, carry_out} = {1'b0, cur_val};
      OP_CLR: result = '0;
      default: valid_op = 1'b0;  // NOP and reserved code
    endcase
  end

endmodule

// File: rtl/register_bank.sv
// Purpose: DEPTH x WIDTH register bank, one op-based write port, two combinational read ports, registered zero/carry flags.
// Latency: writes and flags commit at the sampling edge; reads are combinational (optionally bypassing the in-flight result).
// Backpressure: none; one operation is accepted every cycle.
// Ports: clk, rst (sync, active-high); op/wr_addr/wr_data write port;
//        rd_addr_a/rd_addr_b -> rd_data_a/rd_data_b; zero_flag, carry_flag.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  parameter  int BYPASS = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  op_t              op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_in_range;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             valid_op;
  logic             commit;

  // Addresses past the last register exist when DEPTH is not a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign cur_val     = wr_in_range ? regs[wr_addr] : '0;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .cur_val   (cur_val),
    .op        (op),
    .wr_data   (wr_data),
    .result    (result),
    .carry_out (carry_out),
    .valid_op  (valid_op)
  );

  // Reset wins over any op, so a write in a reset cycle is neither stored nor forwarded.
  assign commit = !rst && valid_op && wr_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (commit) begin
      regs[wr_addr] <= result;
      zero_flag     <= (result == '0);
      carry_flag    <= carry_out;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if ({1'b0, addr} < DEPTH_L) begin
      if ((BYPASS != 0) && commit && (addr == wr_addr)) begin
        val = result;
      end else begin
        val = regs[addr];
      end
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] ra;
  logic [1:0] rb;

  logic [7:0] rda0, rdb0, rda1, rdb1;
  logic       z0, c0, z1, c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: default bank (4 regs, bypass); u1: 3 regs without bypass.
  register_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .op(op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda0), .rd_data_b(rdb0),
    .zero_flag(z0), .carry_flag(c0)
  );

  register_bank #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .op(op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda1), .rd_data_b(rdb1),
    .zero_flag(z1), .carry_flag(c1)
  );

  // Reference model: plain integer arithmetic per instance.
  int         mdep [2];
  bit         mbyp [2];
  logic [7:0] mreg [2][4];
  logic       mz   [2];
  logic       mc   [2];

  function automatic void model_op(input int cur, input int o, input int d,
                                   output int res, output logic cy, output bit v);
    v   = 1'b1;
    cy  = 1'b0;
    res = cur;
    case (o)
      1: res = d;
      2: begin res = (cur + 1) % 256; cy = (cur == 255); end
      3: begin res = (cur + 255) % 256; cy = (cur == 0); end
      4: begin res = (cur * 2) % 256; cy = (cur >= 128); end
      5: begin res = cur / 2; cy = (cur % 2) == 1; end
      6: res = 0;
      default: v = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_rd(input int i, input logic [1:0] a);
    int   r;
    logic cy;
    bit   v;
    if (int'(a) >= mdep[i]) return 8'h00;
    if (mbyp[i] && !rst && int'(wr_addr) < mdep[i] && a == wr_addr) begin
      model_op(int'(mreg[i][wr_addr]), int'(op), int'(wr_data), r, cy, v);
      if (v) return 8'(r);
    end
    return mreg[i][a];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: check read ports mid-cycle, advance model at the edge, check flags after it.
  task automatic cycle();
    int   r;
    logic cy;
    bit   v;
    @(negedge clk);
    if (!rst) begin
      chk("rd_a_u0", rda0, exp_rd(0, ra));
      chk("rd_b_u0", rdb0, exp_rd(0, rb));
      chk("rd_a_u1", rda1, exp_rd(1, ra));
      chk("rd_b_u1", rdb1, exp_rd(1, rb));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) mreg[i][k] = 8'h00;
        mz[i] = 1'b0;
        mc[i] = 1'b0;
      end else if (int'(wr_addr) < mdep[i]) begin
        model_op(int'(mreg[i][wr_addr]), int'(op), int'(wr_data), r, cy, v);
        if (v) begin
          mreg[i][wr_addr] = 8'(r);
          mz[i] = (r == 0);
          mc[i] = cy;
        end
      end
    end
    #1;
    chk("zero_u0", {7'd0, z0}, {7'd0, mz[0]});
    chk("carry_u0", {7'd0, c0}, {7'd0, mc[0]});
    chk("zero_u1", {7'd0, z1}, {7'd0, mz[1]});
    chk("carry_u1", {7'd0, c1}, {7'd0, mc[1]});
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d);
    op = o; wr_addr = a; wr_data = d;
    cycle();
  endtask

  task automatic idle_read(input logic [1:0] a, input logic [1:0] b);
    op = 3'd0; ra = a; rb = b;
    #1;
  endtask

  initial begin
    mdep[0] = 4; mbyp[0] = 1'b1;
    mdep[1] = 3; mbyp[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) mreg[i][k] = 8'h00;
      mz[i] = 1'b0; mc[i] = 1'b0;
    end

    // Reset with a competing LOAD r1=0x55.
    rst = 1'b1; op = 3'd1; wr_addr = 2'd1; wr_data = 8'h55; ra = 2'd0; rb = 2'd1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      idle_read(2'(a), 2'(a));
      chk("rst_rd_u0", rda0, 8'h00);
      chk("rst_rd_u1", rdb1, 8'h00);
    end
    chk("rst_zero", {7'd0, z0}, 8'h00);
    chk("rst_carry", {7'd0, c0}, 8'h00);

    // LOAD and readback.
    do_op(3'd1, 2'd2, 8'hA5);
    idle_read(2'd2, 2'd0);
    chk("ld_rd_a", rda0, 8'hA5);
    chk("ld_rd_b", rdb0, 8'h00);
    chk("ld_zero", {7'd0, z0}, 8'h00);

    // INC wrap then DEC borrow on r0.
    do_op(3'd1, 2'd0, 8'hFF);
    do_op(3'd2, 2'd0, 8'h00);
    idle_read(2'd0, 2'd0);
    chk("inc_wrap_val", rda0, 8'h00);
    chk("inc_wrap_z", {7'd0, z0}, 8'h01);
    chk("inc_wrap_c", {7'd0, c0}, 8'h01);
    do_op(3'd3, 2'd0, 8'h00);
    idle_read(2'd0, 2'd0);
    chk("dec_val", rda0, 8'hFF);
    chk("dec_c", {7'd0, c0}, 8'h01);
    chk("dec_z", {7'd0, z0}, 8'h00);

    // Shifts on r3 (out of range for u1).
    do_op(3'd1, 2'd3, 8'h81);
    do_op(3'd4, 2'd3, 8'h00);
    idle_read(2'd3, 2'd3);
    chk("shl_val", rda0, 8'h02);
    chk("shl_c", {7'd0, c0}, 8'h01);
    do_op(3'd5, 2'd3, 8'h00);
    idle_read(2'd3, 2'd3);
    chk("shr1_val", rda0, 8'h01);
    chk("shr1_c", {7'd0, c0}, 8'h00);
    do_op(3'd5, 2'd3, 8'h00);
    idle_read(2'd3, 2'd3);
    chk("shr2_val", rda0, 8'h00);
    chk("shr2_c", {7'd0, c0}, 8'h01);
    chk("shr2_z", {7'd0, z0}, 8'h01);
    chk("oob_rd_u1", rda1, 8'h00);

    // Bypass vs stored view on the same INC.
    do_op(3'd1, 2'd1, 8'h10);
    op = 3'd2; wr_addr = 2'd1; ra = 2'd1; rb = 2'd0;
    #1;
    chk("byp_on", rda0, 8'h11);
    chk("byp_off", rda1, 8'h10);
    cycle();

    // Back-to-back INC from 0xFE.
    do_op(3'd1, 2'd1, 8'hFE);
    do_op(3'd2, 2'd1, 8'h00);
    do_op(3'd2, 2'd1, 8'h00);
    idle_read(2'd1, 2'd1);
    chk("b2b_val", rda0, 8'h00);
    chk("b2b_c", {7'd0, c0}, 8'h01);

    // Ignored ops: out-of-range LOAD on u1, reserved code on r0.
    do_op(3'd1, 2'd3, 8'h00);
    do_op(3'd7, 2'd0, 8'h3C);
    idle_read(2'd3, 2'd0);
    chk("ign_rd3_u1", rda1, 8'h00);
    chk("ign_r0_u0", rdb0, 8'hFF);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 59) == 0);
      op      = 3'($urandom_range(0, 7));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) wr_data = 8'hFF;
      ra      = 2'($urandom_range(0, 3));
      rb      = ($urandom_range(0, 1) == 0) ? wr_addr : 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
